// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, FSM state type and ID decode for the register-file read port
package rf_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_NREG  = 16;
  localparam int RF_AW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } rd_state_t;

  function automatic logic [RF_NREG-1:0] decode_id(input logic [RF_AW-1:0] id);
    logic [RF_NREG-1:0] onehot;
    onehot     = '0;
    onehot[id] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rf_operand_capture.sv
// rtl/rf_operand_capture.sv - per-port operand capture with zero-register forcing and write bypass
module rf_operand_capture
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [AW-1:0]    src,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] bitline,
  output logic [WIDTH-1:0] data
);

  // The cell flop only updates at this same edge, so a concurrent write must be forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (cap) begin
      if (src == '0)
        data <= '0;
      else if (wr_en && (wr_reg == src))
        data <= wr_data;
      else
        data <= bitline;
    end
  end

endmodule

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - two-source read sequencer driving one-hot read enables and returning operands
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREG  = RF_NREG,
  parameter int AW    = RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_src1,
  input  logic [AW-1:0]    req_src2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NREG-1:0]  rd_en1,
  output logic [NREG-1:0]  rd_en2,
  input  logic [WIDTH-1:0] bitline1,
  input  logic [WIDTH-1:0] bitline2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data1,
  output logic [WIDTH-1:0] rsp_data2
);

  rd_state_t     state;
  logic [AW-1:0] src1_q;
  logic [AW-1:0] src2_q;
  logic          drive;

  assign drive = (state == DRIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src1_q    <= '0;
      src2_q    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            src1_q <= req_src1;
            src2_q <= req_src2;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (req_valid) begin
              src1_q <= req_src1;
              src2_q <= req_src2;
              state  <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Enables exist only in DRIVE, so a floating bitline is never sampled.
  always_comb begin
    rd_en1 = '0;
    rd_en2 = '0;
    if (drive) begin
      rd_en1 = decode_id(src1_q);
      rd_en2 = decode_id(src2_q);
    end
  end

  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    req_ready = 1'b1;
        HOLD:    req_ready = rsp_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  rf_operand_capture #(.WIDTH(WIDTH), .AW(AW)) u_cap1 (
    .clk     (clk),
    .rst     (rst),
    .cap     (drive),
    .src     (src1_q),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .bitline (bitline1),
    .data    (rsp_data1)
  );

  rf_operand_capture #(.WIDTH(WIDTH), .AW(AW)) u_cap2 (
    .clk     (clk),
    .rst     (rst),
    .cap     (drive),
    .src     (src2_q),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .bitline (bitline2),
    .data    (rsp_data2)
  );

endmodule
